// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bus of the serial subtractor.
// Optional ovf signal exists only when SUB_OVERFLOW_FLAG_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
`ifdef SUB_OVERFLOW_FLAG_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
`ifdef SUB_OVERFLOW_FLAG_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell plus borrow FF.
// Optional signed-overflow flag enabled by SUB_OVERFLOW_FLAG_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  serial_subtractor_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_bout;

  logic w_x;
  logic w_y;
  logic w_d;
  logic w_bnext;

  assign w_x     = r_ra[0];
  assign w_y     = r_rb[0];
  assign w_d     = w_x ^ w_y ^ r_borrow;
  assign w_bnext = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);

`ifdef SUB_OVERFLOW_FLAG_EN
  logic r_ovf;
  logic r_a_msb;
  logic r_b_msb;
  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_ra     <= '0;
      r_rb     <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bout   <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
      r_ovf    <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          // Accepting from DONE gives back-to-back operation without an IDLE gap.
          if (bus.start) begin
            r_ra     <= bus.a;
            r_rb     <= bus.b;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SHIFT;
`ifdef SUB_OVERFLOW_FLAG_EN
            r_a_msb  <= bus.a[WIDTH-1];
            r_b_msb  <= bus.b[WIDTH-1];
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_diff   <= {w_d, r_diff[WIDTH-1:1]};
          r_ra     <= r_ra >> 1;
          r_rb     <= r_rb >> 1;
          r_borrow <= w_bnext;
          r_count  <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bout  <= w_bnext;
`ifdef SUB_OVERFLOW_FLAG_EN
            // w_d is the result MSB on the final shift.
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed scoreboard bench for serial_subtractor.
// ovf checks are compiled in only with SUB_OVERFLOW_FLAG_EN.
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t last_exp;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.diff = a - b;
    e.bout = (a < b);
    e.ovf  = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
    return e;
  endfunction

  // Drive a request for one cycle, then scramble operands to show they are not re-sampled.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    q.push_back(model(a, b));
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  // Count remaining busy cycles, then compare the DONE cycle against the scoreboard.
  task automatic wait_done(input string tag, input int exp_busy);
    int n = 0;
    int overlap = 0;
    while (bus.busy === 1'b1 && n < 4 * W) begin
      if (bus.done !== 1'b0) overlap++;
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, n, exp_busy);
    chk({tag, "_busy_done_overlap"}, overlap, 0);
    chk({tag, "_done"}, {31'b0, bus.done}, 1);
    if (q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      last_exp = q.pop_front();
      chk({tag, "_diff"}, {24'b0, bus.diff}, {24'b0, last_exp.diff});
      chk({tag, "_bout"}, {31'b0, bus.bout}, {31'b0, last_exp.bout});
`ifdef SUB_OVERFLOW_FLAG_EN
      chk({tag, "_ovf"}, {31'b0, bus.ovf}, {31'b0, last_exp.ovf});
`endif
    end
  endtask

  task automatic after_done(input string tag);
    tick();
    chk({tag, "_done_pulse_one_cycle"}, {31'b0, bus.done}, 0);
    chk({tag, "_idle_not_busy"}, {31'b0, bus.busy}, 0);
    tick();
    tick();
    chk({tag, "_diff_held"}, {24'b0, bus.diff}, {24'b0, last_exp.diff});
    chk({tag, "_bout_held"}, {31'b0, bus.bout}, {31'b0, last_exp.bout});
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(a, b);
    wait_done(tag, W);
    after_done(tag);
  endtask

  initial begin
    int ndone;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_diff", {24'b0, bus.diff}, 0);
    chk("rst_bout", {31'b0, bus.bout}, 0);
`ifdef SUB_OVERFLOW_FLAG_EN
    chk("rst_ovf", {31'b0, bus.ovf}, 0);
`endif
    rst = 1'b0;
    tick();

    run_op("t5a_23", 8'h5A, 8'h23);
    chk("t5a_23_diff_const", {24'b0, last_exp.diff}, 32'h37);
    run_op("t10_20", 8'h10, 8'h20);
    run_op("t00_00", 8'h00, 8'h00);
    run_op("tff_01", 8'hFF, 8'h01);
    run_op("t80_01", 8'h80, 8'h01);
    run_op("t7f_ff", 8'h7F, 8'hFF);

    // Start during SHIFT must be ignored.
    start_op(8'h05, 8'h03);
    tick();
    tick();
    tick();
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h11;
    tick();
    bus.start = 1'b0;
    wait_done("ignore", W - 4);
    chk("ignore_diff_const", {24'b0, bus.diff}, 32'h02);
    // Back-to-back accept from the DONE cycle.
    start_op(8'h09, 8'h09);
    wait_done("b2b", W);
    after_done("b2b");

    // Reset mid-operation discards the request.
    start_op(8'h80, 8'h7F);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    chk("midrst_busy", {31'b0, bus.busy}, 0);
    chk("midrst_done", {31'b0, bus.done}, 0);
    chk("midrst_diff", {24'b0, bus.diff}, 0);
    chk("midrst_bout", {31'b0, bus.bout}, 0);
    ndone = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (bus.done === 1'b1) ndone++;
      tick();
    end
    chk("midrst_no_done", ndone, 0);
    run_op("post_rst", 8'h80, 8'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
